// File: rtl/addsub_acc_ctrl_if.sv
// addsub_acc_ctrl_if
// Request/response bundle for the add/sub accumulator controller.
//   in_valid/in_ready/in_op/in_data : operation request handshake (master -> slave)
//   out_valid/out_ready             : result handshake (slave -> master)
//   out_acc/out_cout/out_ovf/out_zero : registered result and flags
// The controller takes the slave modport; the requester/consumer takes master.
interface addsub_acc_ctrl_if #(
    parameter int N = 4
);
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_op;
    logic [N-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_acc;
    logic         out_cout;
    logic         out_ovf;
    logic         out_zero;

    modport master (
        output in_valid, in_op, in_data, out_ready,
        input  in_ready, out_valid, out_acc, out_cout, out_ovf, out_zero
    );

    modport slave (
        input  in_valid, in_op, in_data, out_ready,
        output in_ready, out_valid, out_acc, out_cout, out_ovf, out_zero
    );
endinterface

// File: rtl/addsub_acc_ctrl.sv
// addSubComd
// N-bit combinational add/subtract stage.
//   a, b : operands      sub : 1 = a - b, 0 = a + b
//   s    : result mod 2^N cout : carry out (for subtract, 1 = no borrow)
module addSubComd #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic [N-1:0] s,
    output logic         cout
);
    logic [N:0] sum_full;

    // Subtract as a + ~b + 1 so cout carries the no-borrow meaning.
    assign sum_full = {1'b0, a} + {1'b0, b ^ {N{sub}}} + {{N{1'b0}}, sub};
    assign s        = sum_full[N-1:0];
    assign cout     = sum_full[N];
endmodule

// addsub_acc_ctrl
// Accumulator controller around addSubComd. Accepts CLR/LOAD/ADD/SUB requests,
// updates the accumulator one cycle later and holds the result until consumed.
//   clk      : rising-edge clock
//   rst      : synchronous active-high reset
//   bus      : request/result handshake (slave side)
//   op_count : results accepted by the consumer, wraps at 2^CNT_W
//
// state | meaning
// IDLE  | ready for a request, last result held on outputs
// EXEC  | accumulator and flags updated from latched op/operand
// RESP  | result presented, waiting for out_ready
module addsub_acc_ctrl #(
    parameter int N     = 4,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    addsub_acc_ctrl_if.slave   bus,
    output logic [CNT_W-1:0]   op_count
);
    localparam logic [1:0] OP_CLR  = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_ADD  = 2'b10;
    localparam logic [1:0] OP_SUB  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [N-1:0]     data_q, data_d;
    logic [N-1:0]     acc_q, acc_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [N-1:0]     st_s;
    logic             st_cout;

    addSubComd #(.N(N)) u_addsub (
        .a    (acc_q),
        .b    (data_q),
        .sub  (op_q == OP_SUB),
        .s    (st_s),
        .cout (st_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            data_q  <= '0;
            acc_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            acc_q   <= acc_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        data_d        = data_q;
        acc_d         = acc_q;
        cout_d        = cout_q;
        ovf_d         = ovf_q;
        zero_d        = zero_q;
        cnt_d         = cnt_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;

        case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    op_d    = bus.in_op;
                    data_d  = bus.in_data;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                case (op_q)
                    OP_CLR: begin
                        acc_d  = '0;
                        cout_d = 1'b0;
                        ovf_d  = 1'b0;
                    end
                    OP_LOAD: begin
                        acc_d  = data_q;
                        cout_d = 1'b0;
                        ovf_d  = 1'b0;
                    end
                    OP_ADD: begin
                        acc_d  = st_s;
                        cout_d = st_cout;
                        ovf_d  = (acc_q[N-1] == data_q[N-1]) && (st_s[N-1] != acc_q[N-1]);
                    end
                    default: begin
                        acc_d  = st_s;
                        cout_d = st_cout;
                        ovf_d  = (acc_q[N-1] != data_q[N-1]) && (st_s[N-1] != acc_q[N-1]);
                    end
                endcase
                zero_d  = (acc_d == '0);
                state_d = RESP;
            end
            RESP: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.out_acc  = acc_q;
    assign bus.out_cout = cout_q;
    assign bus.out_ovf  = ovf_q;
    assign bus.out_zero = zero_q;
    assign op_count     = cnt_q;
endmodule

// File: tb/tb_addsub_acc_ctrl.sv
// tb_addsub_acc_ctrl
// Directed bench for addsub_acc_ctrl with hand-computed expected results.
module tb_addsub_acc_ctrl;
    logic       clk;
    logic       rst;
    logic [7:0] op_count;
    logic [7:0] exp_cnt;
    int         checks;
    int         errors;

    addsub_acc_ctrl_if #(.N(4)) bus ();

    addsub_acc_ctrl #(.N(4), .CNT_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .op_count (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full request/response round trip; checks timing and result.
    task automatic do_op(input string nm, input logic [1:0] op, input logic [3:0] d,
                         input logic [3:0] ea, input logic ec, input logic eo, input logic ez);
        chk({nm, " idle in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_data  = d;
        tick();
        bus.in_valid = 1'b0;
        bus.in_data  = 4'h0;
        chk({nm, " exec in_ready"}, 32'(bus.in_ready), 32'd0);
        chk({nm, " exec out_valid"}, 32'(bus.out_valid), 32'd0);
        tick();
        chk({nm, " resp out_valid"}, 32'(bus.out_valid), 32'd1);
        chk({nm, " acc"}, 32'(bus.out_acc), 32'(ea));
        chk({nm, " cout"}, 32'(bus.out_cout), 32'(ec));
        chk({nm, " ovf"}, 32'(bus.out_ovf), 32'(eo));
        chk({nm, " zero"}, 32'(bus.out_zero), 32'(ez));
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        exp_cnt = exp_cnt + 8'd1;
        chk({nm, " post out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({nm, " op_count"}, 32'(op_count), 32'(exp_cnt));
        chk({nm, " acc held"}, 32'(bus.out_acc), 32'(ea));
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        exp_cnt       = 8'd0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_op     = 2'b00;
        bus.in_data   = 4'h0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // reset state
        chk("rst in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst acc", 32'(bus.out_acc), 32'd0);
        chk("rst cout", 32'(bus.out_cout), 32'd0);
        chk("rst ovf", 32'(bus.out_ovf), 32'd0);
        chk("rst zero", 32'(bus.out_zero), 32'd1);
        chk("rst op_count", 32'(op_count), 32'd0);

        // reset during EXEC aborts a pending LOAD 0100
        bus.in_valid = 1'b1;
        bus.in_op    = 2'b01;
        bus.in_data  = 4'b0100;
        tick();
        bus.in_valid = 1'b0;
        chk("abort in EXEC", 32'(bus.in_ready), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort in_ready", 32'(bus.in_ready), 32'd1);
        chk("abort out_valid", 32'(bus.out_valid), 32'd0);
        chk("abort acc", 32'(bus.out_acc), 32'd0);
        chk("abort zero", 32'(bus.out_zero), 32'd1);
        chk("abort op_count", 32'(op_count), 32'd0);
        tick();
        chk("abort stays idle", 32'(bus.out_valid), 32'd0);
        chk("abort acc stays", 32'(bus.out_acc), 32'd0);

        //      name          op     data     acc      cout  ovf   zero
        do_op("add1",       2'b10, 4'b0001, 4'b0001, 1'b0, 1'b0, 1'b0);
        do_op("load8",      2'b01, 4'b1000, 4'b1000, 1'b0, 1'b0, 1'b0);
        do_op("sub1 ovf",   2'b11, 4'b0001, 4'b0111, 1'b1, 1'b1, 1'b0);
        do_op("clr",        2'b00, 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b1);
        do_op("sub1 brw",   2'b11, 4'b0001, 4'b1111, 1'b0, 1'b0, 1'b0);
        do_op("loadA",      2'b01, 4'b1010, 4'b1010, 1'b0, 1'b0, 1'b0);
        do_op("add5",       2'b10, 4'b0101, 4'b1111, 1'b0, 1'b0, 1'b0);
        do_op("add1 wrap",  2'b10, 4'b0001, 4'b0000, 1'b1, 1'b0, 1'b1);
        do_op("add7",       2'b10, 4'b0111, 4'b0111, 1'b0, 1'b0, 1'b0);
        do_op("add1 povf",  2'b10, 4'b0001, 4'b1000, 1'b0, 1'b1, 1'b0);
        do_op("clr2",       2'b00, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1);

        // backpressure: ADD 0011 from 0000, in_valid kept high throughout
        bus.in_valid = 1'b1;
        bus.in_op    = 2'b10;
        bus.in_data  = 4'b0011;
        tick();
        bus.in_data  = 4'b0001;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp out_valid %0d", i), 32'(bus.out_valid), 32'd1);
            chk($sformatf("bp in_ready %0d", i), 32'(bus.in_ready), 32'd0);
            chk($sformatf("bp acc %0d", i), 32'(bus.out_acc), 32'h3);
            chk($sformatf("bp cout %0d", i), 32'(bus.out_cout), 32'd0);
            chk($sformatf("bp zero %0d", i), 32'(bus.out_zero), 32'd0);
            chk($sformatf("bp op_count %0d", i), 32'(op_count), 32'(exp_cnt));
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        exp_cnt = exp_cnt + 8'd1;
        chk("bp release op_count", 32'(op_count), 32'(exp_cnt));
        chk("bp release out_valid", 32'(bus.out_valid), 32'd0);
        chk("bp release in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        tick();
        chk("bp no queued op", 32'(bus.out_valid), 32'd0);
        chk("bp acc unchanged", 32'(bus.out_acc), 32'h3);
        chk("bp op_count once", 32'(op_count), 32'(exp_cnt));

        // 256 back-to-back ADD 0001 from a fresh reset: count wraps to 0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("wrap start op_count", 32'(op_count), 32'd0);
        bus.in_valid  = 1'b1;
        bus.in_op     = 2'b10;
        bus.in_data   = 4'b0001;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 255 * 3; i++) tick();
        chk("wrap 255 op_count", 32'(op_count), 32'd255);
        chk("wrap 255 acc", 32'(bus.out_acc), 32'hF);
        for (int i = 0; i < 3; i++) tick();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("wrap 256 op_count", 32'(op_count), 32'd0);
        chk("wrap 256 acc", 32'(bus.out_acc), 32'h0);
        chk("wrap 256 cout", 32'(bus.out_cout), 32'd1);
        chk("wrap 256 zero", 32'(bus.out_zero), 32'd1);
        chk("wrap idle", 32'(bus.in_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/addsub_acc_ctrl.md
# addsub_acc_ctrl

Sequential accumulator controller that sits directly downstream of the team's N-bit combinational add/subtract stage (`addSubComd`: ports a, b, sub, s, cout). It accepts operation requests over a valid/ready handshake, drives the add/sub stage with the accumulator and the request operand, captures the sum, carry and derived flags into registers, and returns each result over a valid/ready output handshake with backpressure.

## Interface
- N, 4, data width of the operand, accumulator and add/sub stage
- CNT_W, 8, width of the completed-operation counter
- clk  input  1  rising-edge clock, the only clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  request present
- in_ready  output  1  block can accept a request
- in_op  input  2  00 CLR, 01 LOAD, 10 ADD, 11 SUB
- in_data  input  N  operand B (ignored for CLR)
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- out_acc  output  N  accumulator value after the operation
- out_cout  output  1  carry out of the add/sub stage (SUB: 1 = no borrow)
- out_ovf  output  1  two's-complement signed overflow
- out_zero  output  1  out_acc == 0
- op_count  output  CNT_W  number of results accepted by the consumer, wraps

## Operation
- Instantiates one `addSubComd` with a = acc register, b = latched operand, sub = (latched op == SUB).
- FSM states: IDLE, EXEC, RESP.
  - IDLE: in_ready = 1. On in_valid: latch in_op and in_data, go to EXEC. Otherwise stay.
  - EXEC: in_ready = 0. Update acc and flags per latched op, go to RESP.
  - RESP: out_valid = 1, outputs stable. On out_ready: op_count += 1 (mod 2^CNT_W), go to IDLE. Otherwise hold.
- Per-op update in EXEC:
  - CLR: acc = 0, cout = 0, ovf = 0.
  - LOAD: acc = in_data latched, cout = 0, ovf = 0.
  - ADD: acc = s, cout = cout of stage, ovf = (a[N-1] == b[N-1]) && (s[N-1] != a[N-1]).
  - SUB: acc = s, cout = cout of stage, ovf = (a[N-1] != b[N-1]) && (s[N-1] != a[N-1]).
  - zero = (new acc == 0) for every op.
- All arithmetic is modulo 2^N, with no saturation. Carry beyond bit N-1 appears only in out_cout.
- The acc register persists across operations and changes only in EXEC or on reset.

## Timing
- Reset (rst high at a clk edge): state = IDLE, acc = 0, latched op/data = 0, out_valid = 0, out_acc = 0, out_cout = 0, out_ovf = 0, out_zero = 1, op_count = 0, in_ready = 1 on the following cycle.
- Reset has priority over every other input. Reset in EXEC or RESP aborts the operation: no result is presented and op_count does not increment.
- Latency: request accepted at edge t, acc updated at edge t+1, out_valid high from t+1 until the accepting edge.
- Throughput: at most one operation per 3 cycles with out_ready held high.
- in_ready is 0 throughout EXEC and RESP. in_valid during those states is ignored and is not queued.
- out_acc, out_cout, out_ovf and out_zero are registered. They are unchanged while out_valid = 1 and out_ready = 0, and they retain their last values in IDLE.
- op_count wraps from 2^CNT_W − 1 to 0.
- in_valid and out_ready have no combinational path to any output.

## Test plan
- Reset, then ADD 0001 from acc 0000 -> after 2 cycles out_valid = 1, out_acc = 0001, cout = 0, ovf = 0, zero = 0, op_count = 1 after accept.
- LOAD 1000, then SUB 0001 -> out_acc = 0111, cout = 1, ovf = 1. CLR, then SUB 0001 -> out_acc = 1111, cout = 0 (borrow), ovf = 0.
- LOAD 1010, then ADD 0101 -> 1111, cout = 0. Then ADD 0001 -> 0000, cout = 1, zero = 1, ovf = 0.
- Backpressure: hold out_ready = 0 for 5 cycles with in_valid = 1 -> outputs stable, in_ready = 0, no extra op executed. Release -> exactly one accept and op_count increments by 1.
- Reset asserted in EXEC with LOAD 0100 pending -> next cycle IDLE, acc = 0, out_valid = 0, op_count unchanged at 0.
- Run 256 back-to-back accepted ops with CNT_W = 8 -> op_count returns to 0.
